// File: rtl/counter_spi_readout.sv
// counter_spi_readout: SPI mode-0 responder that lets an external master read
// back an atomic snapshot of the counter value or a fixed device-ID byte.
// All SPI pins are synchronised into clk; edges are detected on the
// synchronised copies, so spi_sclk must run at clk/8 or slower.
// Optional build macro: COUNTER_SPI_PARITY_EN appends an even-parity bit
// after the last data bit of a read.

// Synchroniser for one asynchronous pin.
module counter_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  // Shift the raw pin through the chain; the oldest stage is the clean copy.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain register, reset to the pin's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

module counter_spi_readout #(
  parameter int         CNT_WIDTH   = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEV_ID      = 8'h5C
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [CNT_WIDTH-1:0] count_in,
  input  logic                 spi_cs_n,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 miso_oe,
  output logic                 frame_done,
  output logic                 cmd_err
);
  localparam logic [7:0] READ_CNT = 8'hA0;
  localparam logic [7:0] READ_ID  = 8'h9F;
  // Shift register is wide enough for either the counter or the ID byte.
  localparam int SH_W = (CNT_WIDTH > 8) ? CNT_WIDTH : 8;
`ifdef COUNTER_SPI_PARITY_EN
  localparam int BCW = $clog2(SH_W + 2);
`else
  localparam int BCW = $clog2(SH_W + 1);
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA, TAIL} state_t;

  // Pin order in the synchroniser array: {mosi, sclk, cs_n}.
  localparam logic [2:0] SYNC_RST = 3'b001;

  logic [2:0] pin_raw, pin_sync;
  assign pin_raw = {spi_mosi, spi_sclk, spi_cs_n};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    counter_spi_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (SYNC_RST[g])
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pin_raw[g]),
      .q     (pin_sync[g])
    );
  end

  logic cs_s, sclk_s, mosi_s, cs_eff;
  assign cs_s   = pin_sync[0];
  assign sclk_s = pin_sync[1];
  assign mosi_s = pin_sync[2];
  // Dropping ena looks exactly like the master releasing chip select.
  assign cs_eff = cs_s | ~ena;

  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q, cs_prev_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_prev_d = sclk_s;
  assign cs_prev_d   = cs_eff;
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign cs_fall     = ~cs_eff & cs_prev_q;
  assign cs_rise     = cs_eff & ~cs_prev_q;

  // Previous-cycle copies for edge detection (cs idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] snap_q, snap_d;
  logic [7:0]           cmd_q, cmd_d, cmd_shift;
  logic [SH_W-1:0]      sh_q, sh_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]       len_q, len_d, last_cnt;
  logic                 tail_ok_q, tail_ok_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef COUNTER_SPI_PARITY_EN
  logic                 parity_q, parity_d;
  assign last_cnt = len_q + BCW'(1);
`else
  assign last_cnt = len_q;
`endif

  assign cmd_shift = {cmd_q[6:0], mosi_s};

  // Frame FSM: command capture, data shift-out, tail and frame termination.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cmd_d     = cmd_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    tail_ok_d = tail_ok_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef COUNTER_SPI_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != IDLE && cs_rise) begin
      // End of frame or abort; only a finished read reports completion.
      state_d   = IDLE;
      oe_d      = 1'b0;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      done_d    = (state_q == TAIL) && tail_ok_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            snap_d    = count_in;
            oe_d      = 1'b1;
            miso_d    = 1'b0;
            cmd_d     = '0;
            bit_cnt_d = '0;
            tail_ok_d = 1'b0;
`ifdef COUNTER_SPI_PARITY_EN
            parity_d  = 1'b0;
`endif
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d = cmd_shift;
            if (bit_cnt_q == BCW'(7)) begin
              bit_cnt_d = '0;
              case (cmd_shift)
                READ_CNT: begin
                  state_d = DATA;
                  sh_d    = SH_W'(snap_q) << (SH_W - CNT_WIDTH);
                  len_d   = BCW'(CNT_WIDTH);
                end
                READ_ID: begin
                  state_d = DATA;
                  sh_d    = SH_W'(DEV_ID) << (SH_W - 8);
                  len_d   = BCW'(8);
                end
                default: begin
                  state_d   = TAIL;
                  tail_ok_d = 1'b0;
                  err_d     = 1'b1;
                end
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end
        DATA: begin
          // bit_cnt counts bits already driven onto miso.
          if (sclk_fall) begin
            if (bit_cnt_q < len_q) begin
              miso_d    = sh_q[SH_W-1];
              sh_d      = sh_q << 1;
              bit_cnt_d = bit_cnt_q + BCW'(1);
`ifdef COUNTER_SPI_PARITY_EN
              parity_d  = parity_q ^ sh_q[SH_W-1];
            end else if (bit_cnt_q == len_q) begin
              miso_d    = parity_q;
              bit_cnt_d = bit_cnt_q + BCW'(1);
`endif
            end
          end else if (sclk_rise && bit_cnt_q == last_cnt) begin
            // Master has sampled the final bit.
            state_d   = TAIL;
            tail_ok_d = 1'b1;
            miso_d    = 1'b0;
          end
        end
        TAIL: begin
          miso_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      cmd_q     <= '0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      len_q     <= '0;
      tail_ok_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef COUNTER_SPI_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      cmd_q     <= cmd_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      tail_ok_q <= tail_ok_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef COUNTER_SPI_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign spi_miso   = miso_q;
  assign miso_oe    = oe_q;
  assign frame_done = done_q;
  assign cmd_err    = err_q;
endmodule

// File: tb/tb_counter_spi_readout.sv
// Bench for counter_spi_readout: table vectors, hand-written corner
// sequences (abort, reset, ena drop) and randomized frames against a
// bit-level model of what the master should receive.
module tb_counter_spi_readout;
  localparam int H = 8;  // sclk half period in clk cycles
`ifdef COUNTER_SPI_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ena, spi_cs_n, spi_sclk, spi_mosi;
  logic [15:0] count_in;
  logic        spi_miso, miso_oe, frame_done, cmd_err;

  counter_spi_readout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .count_in   (count_in),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .miso_oe    (miso_oe),
    .frame_done (frame_done),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tot_done = 0;
  int tot_cerr = 0;

  always @(negedge clk) begin
    if (frame_done) tot_done++;
    if (cmd_err)    tot_cerr++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 3ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(H);
  endtask

  // One mode-0 bit: master drives mosi, samples miso at the rise, then falls.
  task automatic spi_bit(input logic b, output logic s);
    spi_mosi = b;
    wait_clk(H);
    s = spi_miso;
    spi_sclk = 1'b1;
    wait_clk(H);
    spi_sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int nclk, input bit chg,
                           input logic [15:0] chg_val, output logic [31:0] rx,
                           output logic oe_mid, output logic oe_after,
                           output int nd, output int ne);
    int d0, e0;
    logic s;
    d0 = tot_done;
    e0 = tot_cerr;
    cs_low();
    oe_mid = miso_oe;
    if (chg) count_in = chg_val;
    for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], s);
    rx = '0;
    for (int i = 0; i < nclk; i++) begin
      spi_bit(1'($urandom_range(0, 1)), s);
      rx = {rx[30:0], s};
    end
    cs_high();
    oe_after = miso_oe | spi_miso;
    nd = tot_done - d0;
    ne = tot_cerr - e0;
  endtask

  // Reference: bit the master should see on data clock i.
  function automatic logic exp_bit(input logic [7:0] cmd, input logic [15:0] snap, input int i);
    int len;
    logic [15:0] d;
    if (cmd == 8'hA0)      begin len = 16; d = snap; end
    else if (cmd == 8'h9F) begin len = 8;  d = {8'h5C, 8'h00}; end
    else return 1'b0;
    if (i < len) return d[15-i];
    if (PB == 1 && i == len) return ^d;
    return 1'b0;
  endfunction

  function automatic int cmd_len(input logic [7:0] cmd);
    if (cmd == 8'hA0) return 16;
    if (cmd == 8'h9F) return 8;
    return -1;
  endfunction

  typedef struct {
    logic [15:0] cnt;
    logic [7:0]  cmd;
    int          nclk;
    logic [31:0] exp_rx;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] rx, mrx;
    logic        oe_mid, oe_after, s;
    int          nd, ne, d0, e0, len, nclk;
    logic [7:0]  cmd;
    logic [15:0] cnt, cnt2;
    bit          chg;

`ifdef COUNTER_SPI_PARITY_EN
    tbl[0] = '{16'h1234, 8'hA0, 17, 32'h0000_2469, 1, 0};
    tbl[1] = '{16'h0000, 8'h9F,  9, 32'h0000_00B8, 1, 0};
    tbl[4] = '{16'h1234, 8'hA0, 20, 32'h0001_2348, 1, 0};
`else
    tbl[0] = '{16'h1234, 8'hA0, 16, 32'h0000_1234, 1, 0};
    tbl[1] = '{16'h0000, 8'h9F,  8, 32'h0000_005C, 1, 0};
    tbl[4] = '{16'h1234, 8'hA0, 20, 32'h0001_2340, 1, 0};
`endif
    tbl[2] = '{16'hBEEF, 8'h33, 16, 32'h0000_0000, 0, 1};
    tbl[3] = '{16'h00FF, 8'hA0, 16 + PB, 32'h0000_00FF << PB, 1, 0};

    rst_n = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0;
    spi_mosi = 1'b0; count_in = '0;
    wait_clk(3);
    chk("reset_outputs", {28'd0, spi_miso, miso_oe, frame_done, cmd_err}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      count_in = tbl[v].cnt;
      run_frame(tbl[v].cmd, tbl[v].nclk, 1'b0, 16'h0, rx, oe_mid, oe_after, nd, ne);
      chk($sformatf("tbl%0d_rx", v), rx, tbl[v].exp_rx);
      chk($sformatf("tbl%0d_done", v), nd, tbl[v].exp_done);
      chk($sformatf("tbl%0d_err", v), ne, tbl[v].exp_err);
      chk($sformatf("tbl%0d_oe_mid", v), oe_mid, 1);
      chk($sformatf("tbl%0d_oe_after", v), oe_after, 0);
    end

    // Snapshot atomicity: count changes after cs_n falls
    count_in = 16'h1234;
    run_frame(8'hA0, 16, 1'b1, 16'hFFFF, rx, oe_mid, oe_after, nd, ne);
    chk("atomic_rx", rx, 32'h1234);
    chk("atomic_done", nd, PB == 1 ? 0 : 1);

    // Abort after 5 command bits, then a clean read
    d0 = tot_done; e0 = tot_cerr;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(i == 0, s);
    cs_high();
    chk("abort_pulses", (tot_done - d0) + (tot_cerr - e0), 0);
    chk("abort_oe", miso_oe | spi_miso, 0);
    count_in = 16'hA5C3;
    run_frame(8'hA0, 16, 1'b0, 16'h0, rx, oe_mid, oe_after, nd, ne);
    chk("post_abort_rx", rx, 32'hA5C3);
    chk("post_abort_err", ne, 0);

    // Reset mid-DATA
    count_in = 16'h1234;
    cs_low();
    for (int i = 0; i < 8; i++) spi_bit(i == 0 || i == 2, s);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, s);
    chk("pre_rst_oe", miso_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {miso_oe, spi_miso}, 0);
    spi_cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    count_in = 16'h00FF;
    run_frame(8'hA0, 16, 1'b0, 16'h0, rx, oe_mid, oe_after, nd, ne);
    chk("post_rst_rx", rx, 32'h00FF);

    // ena drop mid-DATA behaves like cs_n rising
    d0 = tot_done; e0 = tot_cerr;
    count_in = 16'hFFFF;
    cs_low();
    for (int i = 0; i < 8; i++) spi_bit(i == 0 || i == 2, s);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, s);
    ena = 1'b0;
    wait_clk(2);
    chk("ena_drop_out", {miso_oe, spi_miso}, 0);
    spi_cs_n = 1'b1;
    wait_clk(H);
    ena = 1'b1;
    wait_clk(H);
    chk("ena_drop_pulses", (tot_done - d0) + (tot_cerr - e0), 0);
    count_in = 16'h00FF;
    run_frame(8'hA0, 16, 1'b0, 16'h0, rx, oe_mid, oe_after, nd, ne);
    chk("post_ena_rx", rx, 32'h00FF);

    // Randomized frames against the reference
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    cmd = 8'hA0;
        2:       cmd = 8'h9F;
        default: cmd = 8'($urandom);
      endcase
      nclk = $urandom_range(0, 20);
      cnt  = 16'($urandom);
      cnt2 = 16'($urandom);
      chg  = 1'($urandom_range(0, 1));
      count_in = cnt;
      run_frame(cmd, nclk, chg, cnt2, rx, oe_mid, oe_after, nd, ne);
      mrx = '0;
      for (int i = 0; i < nclk; i++) mrx = {mrx[30:0], exp_bit(cmd, cnt, i)};
      len = cmd_len(cmd);
      chk($sformatf("rnd%0d_rx cmd=%h n=%0d", f, cmd, nclk), rx, mrx);
      chk($sformatf("rnd%0d_done", f), nd, (len > 0 && nclk >= len + PB) ? 1 : 0);
      chk($sformatf("rnd%0d_err", f), ne, (len < 0) ? 1 : 0);
      chk($sformatf("rnd%0d_oe", f), {oe_mid, oe_after}, 2'b10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
